manual_drive_ctrl: RTL
======================

Name: manual_drive_ctrl

Overview:
Sequencing controller for manual-transmission mode. It turns driver controls (power buttons, clutch, throttle, brake, reverse switch) into the 4-bit manual drive state, and owns power-on/off sequencing. It also drives the odometer datapath with a single-cycle increment strobe every 0.5 s while moving, plus a clear strobe at power-up. It sits between the debounced input block and the mileage/display blocks. It replaces the odometer's private divided clock with a clk-domain enable.

Parameters:
TICK_DIV, 50_000_000, clk cycles per 0.5 s tick (100 MHz board); the bench uses 4.
OFF_HOLD_TICKS, 2, consecutive ticks power_off_btn must be held to force power-off (1 s).
IDLE_OFF_TICKS, 20, ticks in NOT_STARTING with no throttle/clutch activity before auto power-off (10 s).

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
power_on_btn  in  1  debounced level; its rising edge requests power-on
power_off_btn  in  1  debounced level; held to request power-off
clutch  in  1  clutch pressed
throttle  in  1  throttle pressed
brake  in  1  brake pressed
reverse_sw  in  1  reverse gear switch level
state  out  4  drive state: OFF=0000, NOT_STARTING=0001, STARTING=0010, MOVING=0100
power_now  out  1  1 in any state except OFF
reverse_now  out  1  registered copy of the accepted reverse gear
odo_inc  out  1  one-cycle pulse: add 1 to mileage
odo_clr  out  1  one-cycle pulse: clear mileage

Behaviour:
- Reset (rst==0 at a clk edge): state=OFF, power_now=0, reverse_now=0, odo_inc=0, odo_clr=0. Tick divider, hold counter, idle counter and edge-detect registers all clear.
- Reset mid-operation has the same effect; there is no partial state.
- Tick: free-running counter 0..TICK_DIV-1. tick=1 for the single cycle where counter==TICK_DIV-1, then the counter wraps to 0. The counter runs in all states.
- Power-off hold counter: increments on each tick while power_off_btn=1; clears whenever power_off_btn=0.
  - When it reaches OFF_HOLD_TICKS and state!=OFF, the next state is OFF.
  - This has the highest priority after reset.
- Transitions, evaluated each cycle in priority order:
  - OFF: rising edge of power_on_btn -> NOT_STARTING; odo_clr=1 that same cycle; reverse_now=0.
  - NOT_STARTING:
    - throttle & ~clutch -> OFF (stall).
    - throttle & clutch -> STARTING.
    - idle counter reaches IDLE_OFF_TICKS -> OFF.
    - Idle counter increments per tick while throttle=0 and clutch=0; any activity clears it. It also clears on entry.
  - STARTING:
    - brake -> NOT_STARTING.
    - throttle & ~clutch -> MOVING.
    - otherwise hold.
  - MOVING:
    - reverse_sw != reverse_now while clutch=0 -> OFF (gear abuse).
    - brake -> NOT_STARTING.
    - clutch -> STARTING.
    - otherwise hold.
- Reverse: in any powered state with clutch=1, reverse_now <= reverse_sw. A change with clutch=0 is ignored except in MOVING, where it causes OFF.
- Simultaneous brake & throttle in STARTING: brake wins. Power-off hold beats every in-state transition.
- A power_on_btn edge while already powered is ignored.
- odo_inc = tick & (state==MOVING), registered 1-cycle latency from tick. The state used is the value before any same-cycle transition, so there is no inc on the cycle of leaving MOVING.
- odo_clr fires only on OFF->NOT_STARTING; it never coincides with odo_inc.
- Odometer wrap at 9_999_999 stays in the mileage block; this controller does not count mileage.
- All outputs are registered.

Decomposition:
- Shared package/header: the state encodings (ST_OFF, ST_NOT_STARTING, ST_STARTING, ST_MOVING), the state width, and the default TICK_DIV. The mileage and display blocks use the same package.
- One sub-module: tick_gen (parameter DIV, ports clk, rst, tick). It is also reusable by the auto-mode blocks.
- The FSM, hold/idle counters and reverse logic live in manual_drive_ctrl.

Test Plan:
1. TICK_DIV=4. Hold rst=0 for 3 cycles, then release -> all outputs 0, state=0000. Pulse power_on_btn -> state=0001, power_now=1, odo_clr high exactly 1 cycle.
2. From NOT_STARTING:
   - clutch+throttle -> state=0010.
   - release clutch, keep throttle -> state=0100.
   - hold 12 cycles -> exactly 3 odo_inc pulses, each 1 cycle wide, 4 cycles apart.
   - then brake -> state=0001 and no further odo_inc.
3. From NOT_STARTING: throttle with clutch=0 -> state=0000, power_now=0. Likewise, no input for IDLE_OFF_TICKS*TICK_DIV=80 cycles -> state=0000.
4. In MOVING: flip reverse_sw with clutch=0 -> state=0000. Repeat with clutch=1 -> state=0010 and reverse_now=1.
5. In MOVING: hold power_off_btn for 2 ticks (≤8 cycles) -> state=0000. Release after 1 tick, then hold again for 1 tick -> no power-off, because the hold counter cleared.
6. Assert rst=0 in MOVING mid-tick -> next edge state=0000 and all outputs 0. After release, the first tick arrives exactly TICK_DIV cycles later.

Source files
------------

// File: rtl/manual_drive_ctrl_pkg.sv
// Shared drive-state encodings and defaults for the manual-mode controller,
// mileage and display blocks.
package manual_drive_ctrl_pkg;

    localparam int unsigned STATE_W = 4;

    typedef logic [STATE_W-1:0] drive_state_t;

    localparam drive_state_t ST_OFF          = 4'b0000;
    localparam drive_state_t ST_NOT_STARTING = 4'b0001;
    localparam drive_state_t ST_STARTING     = 4'b0010;
    localparam drive_state_t ST_MOVING       = 4'b0100;

    // 0.5 s at 100 MHz
    localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

    function automatic logic is_powered(drive_state_t s);
        return s != ST_OFF;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle enable every DIV clk cycles.
module tick_gen
    import manual_drive_ctrl_pkg::*;
#(
    parameter int unsigned DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual-transmission sequencing: drive state, power sequencing, reverse gear
// tracking and odometer increment/clear strobes.
module manual_drive_ctrl
    import manual_drive_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV       = TICK_DIV_DEFAULT,
    parameter int unsigned OFF_HOLD_TICKS = 2,
    parameter int unsigned IDLE_OFF_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on_btn,
    input  logic       power_off_btn,
    input  logic       clutch,
    input  logic       throttle,
    input  logic       brake,
    input  logic       reverse_sw,
    output logic [3:0] state,
    output logic       power_now,
    output logic       reverse_now,
    output logic       odo_inc,
    output logic       odo_clr
);

    localparam int unsigned HOLD_W = $clog2(OFF_HOLD_TICKS + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_OFF_TICKS + 1);

    logic tick;

    drive_state_t      state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              pon_q;
    logic              rev_q, rev_d;
    logic              pwr_q;
    logic              inc_q;
    logic              clr_q, clr_d;
    logic              pon_rise;
    logic              hold_hit;
    logic              idle_hit;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        pon_rise = power_on_btn & ~pon_q;
        hold_hit = (hold_q == HOLD_W'(OFF_HOLD_TICKS));
        idle_hit = (idle_q == IDLE_W'(IDLE_OFF_TICKS));

        // Both counters saturate so a long hold or long idle cannot wrap back below the limit.
        hold_d = hold_q;
        if (!power_off_btn) begin
            hold_d = '0;
        end else if (tick && !hold_hit) begin
            hold_d = hold_q + HOLD_W'(1);
        end

        idle_d = idle_q;
        if (state_q != ST_NOT_STARTING || throttle || clutch) begin
            idle_d = '0;
        end else if (tick && !idle_hit) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        state_d = state_q;
        clr_d   = 1'b0;
        if (hold_hit && is_powered(state_q)) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (pon_rise) begin
                        state_d = ST_NOT_STARTING;
                        clr_d   = 1'b1;
                    end
                end
                ST_NOT_STARTING: begin
                    if (throttle && !clutch) begin
                        state_d = ST_OFF;
                    end else if (throttle && clutch) begin
                        state_d = ST_STARTING;
                    end else if (idle_hit) begin
                        state_d = ST_OFF;
                    end
                end
                ST_STARTING: begin
                    if (brake) begin
                        state_d = ST_NOT_STARTING;
                    end else if (throttle && !clutch) begin
                        state_d = ST_MOVING;
                    end
                end
                ST_MOVING: begin
                    // Shifting into/out of reverse without the clutch kills the engine.
                    if (!clutch && (reverse_sw != rev_q)) begin
                        state_d = ST_OFF;
                    end else if (brake) begin
                        state_d = ST_NOT_STARTING;
                    end else if (clutch) begin
                        state_d = ST_STARTING;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        rev_d = rev_q;
        if (clr_d) begin
            rev_d = 1'b0;
        end else if (is_powered(state_q) && clutch) begin
            rev_d = reverse_sw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_OFF;
            hold_q  <= '0;
            idle_q  <= '0;
            pon_q   <= 1'b0;
            rev_q   <= 1'b0;
            pwr_q   <= 1'b0;
            inc_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idle_q  <= idle_d;
            pon_q   <= power_on_btn;
            rev_q   <= rev_d;
            pwr_q   <= is_powered(state_d);
            inc_q   <= tick && (state_q == ST_MOVING);
            clr_q   <= clr_d;
        end
    end

    assign state       = state_q;
    assign power_now   = pwr_q;
    assign reverse_now = rev_q;
    assign odo_inc     = inc_q;
    assign odo_clr     = clr_q;

endmodule
